pulse_decode: RTL

PULSE_DECODE -- requirements
Module: pulse_decode

---
 rtl/pulse_decode_if.sv | 22 ++
 rtl/pulse_decode.sv | 116 +++++++++++
 2 files changed

// File: rtl/pulse_decode_if.sv
// Window-pulse decoder bus: level input, start/stop strobes and a
// valid/ready width result. master = decoder side, slave = consumer side.
interface pulse_decode_if #(parameter int CNT_W = 16);
  logic             din;
  logic             en1_o;
  logic             en2_o;
  logic             busy;
  logic [CNT_W-1:0] width;
  logic             width_vld;
  logic             width_rdy;
  logic             ovf;

  modport master (
    input  din, width_rdy,
    output en1_o, en2_o, busy, width, width_vld, ovf
  );

  modport slave (
    output din, width_rdy,
    input  en1_o, en2_o, busy, width, width_vld, ovf
  );
endinterface

// File: rtl/pulse_decode.sv
// Decodes a level-coded window on din into start/stop strobes and a measured
// high-time. Optional macro SYNC2_EN adds a second input flop for async din.
module pulse_decode #(
  parameter int CNT_W = 16,
  parameter int MIN_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  pulse_decode_if.master bus
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic             din_s, din_d;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt;
  logic             en1_q, en2_q;
  logic [CNT_W-1:0] width_q;
  logic             vld_q, ovf_q;
  logic             new_res;

  // input stage
`ifdef SYNC2_EN
  logic din_m;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
    end else begin
      din_m <= bus.din;
      din_s <= din_m;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) din_s <= 1'b0;
    else        din_s <= bus.din;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) din_d <= 1'b0;
    else        din_d <= din_s;
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rise) state_nxt = MEAS;
      MEAS: if (fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // width counter, saturating
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (rise)
      cnt <= CNT_ONE;
    else if (state == MEAS && din_s && cnt != CNT_MAX)
      cnt <= cnt + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en1_q <= 1'b0;
      en2_q <= 1'b0;
    end else begin
      en1_q <= rise;
      en2_q <= fall;
    end
  end

  // Pulses shorter than MIN_W only strobe en1/en2; they never touch the result.
  assign new_res = fall && (state == MEAS) && (cnt >= MIN_C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width_q <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (new_res) begin
      if (!vld_q || bus.width_rdy) begin
        width_q <= cnt;
        vld_q   <= 1'b1;
      end else begin
        ovf_q   <= 1'b1;
      end
    end else if (vld_q && bus.width_rdy) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.en1_o     = en1_q;
  assign bus.en2_o     = en2_q;
  assign bus.busy      = (state == MEAS);
  assign bus.width     = width_q;
  assign bus.width_vld = vld_q;
  assign bus.ovf       = ovf_q;

endmodule
